// File: rtl/packet_steer_pkg.sv
// packet_steer_pkg: destination field location, FSM encoding and select codes for packet_steer
package packet_steer_pkg;
  localparam int DST_LSB = 24;
  localparam int DST_WIDTH = 8;
  typedef enum logic {ST_IDLE = 1'b0, ST_IN_PKT = 1'b1} state_t;
  localparam logic [1:0] SEL_DROP = 2'b00;
  localparam logic [1:0] SEL_BCAST = 2'b11;
endpackage

// File: rtl/packet_steer_axis_reg_slice.sv
// axis_reg_slice: one-deep AXI4-Stream register (load/hold/drain) with async active-low reset
module axis_reg_slice #(
  parameter int DW = 256,
  parameter int TW = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [DW-1:0]   s_tdata,
  input  logic [DW/8-1:0] s_tstrb,
  input  logic [TW-1:0]   s_tuser,
  input  logic            s_tlast,
  output logic            can_load,
  output logic [DW-1:0]   m_tdata,
  output logic [DW/8-1:0] m_tstrb,
  output logic [TW-1:0]   m_tuser,
  output logic            m_tlast,
  output logic            m_tvalid,
  input  logic            m_tready
);
  assign can_load = !m_tvalid || m_tready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_tdata  <= '0;
      m_tstrb  <= '0;
      m_tuser  <= '0;
      m_tlast  <= 1'b0;
      m_tvalid <= 1'b0;
    end else if (load) begin
      m_tdata  <= s_tdata;
      m_tstrb  <= s_tstrb;
      m_tuser  <= s_tuser;
      m_tlast  <= s_tlast;
      m_tvalid <= 1'b1;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
endmodule

// File: rtl/packet_steer.sv
// packet_steer: steers each AXIS packet to output 0, output 1, both or nowhere by TUSER dst byte.
// Optional statistics counters are enabled by defining PACKET_STEER_STATS_EN.
module packet_steer
  import packet_steer_pkg::*;
#(
  parameter int         C_AXIS_DATA_WIDTH  = 256,
  parameter int         C_AXIS_TUSER_WIDTH = 128,
  parameter logic [7:0] C_OUT0_MASK        = 8'h55,
  parameter logic [7:0] C_OUT1_MASK        = 8'hAA
) (
  input  logic                             axi_aclk,
  input  logic                             axi_aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic                             s_axis_tvalid,
  input  logic                             s_axis_tlast,
  output logic                             s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]     m_axis_tdata_0,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb_0,
  output logic [C_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser_0,
  output logic                             m_axis_tvalid_0,
  output logic                             m_axis_tlast_0,
  input  logic                             m_axis_tready_0,
  output logic [C_AXIS_DATA_WIDTH-1:0]     m_axis_tdata_1,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb_1,
  output logic [C_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser_1,
  output logic                             m_axis_tvalid_1,
  output logic                             m_axis_tlast_1,
  input  logic                             m_axis_tready_1
`ifdef PACKET_STEER_STATS_EN
  ,
  output logic [31:0]                      pkt_cnt_0,
  output logic [31:0]                      pkt_cnt_1,
  output logic [31:0]                      drop_cnt
`endif
);
  state_t state, state_n;
  logic [1:0] sel_q, sel_q_n, sel_c, sel;
  logic [DST_WIDTH-1:0] dst;
  logic can0, can1, rdy, xfer, load0, load1;
  assign dst   = s_axis_tuser[DST_LSB +: DST_WIDTH];
  assign sel_c = {|(dst & C_OUT1_MASK), |(dst & C_OUT0_MASK)};
  assign sel   = state == ST_IDLE ? sel_c : sel_q;
  assign rdy   = sel == SEL_DROP ? 1'b1 : sel == SEL_BCAST ? can0 && can1 : sel[0] ? can0 : can1;
  // gated by reset so the upstream sees no ready while the block is held in reset
  assign s_axis_tready = axi_aresetn && rdy;
  assign xfer  = s_axis_tvalid && s_axis_tready;
  assign load0 = xfer && sel[0];
  assign load1 = xfer && sel[1];
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) begin
      state <= ST_IDLE;
      sel_q <= SEL_DROP;
    end else begin
      state <= state_n;
      sel_q <= sel_q_n;
    end
  always_comb begin
    state_n = state;
    sel_q_n = sel_q;
    if (xfer) begin
      state_n = s_axis_tlast ? ST_IDLE : ST_IN_PKT;
      sel_q_n = sel;
    end
  end
  axis_reg_slice #(.DW(C_AXIS_DATA_WIDTH), .TW(C_AXIS_TUSER_WIDTH)) u_slice_0 (
    .clk(axi_aclk), .rst_n(axi_aresetn), .load(load0),
    .s_tdata(s_axis_tdata), .s_tstrb(s_axis_tstrb), .s_tuser(s_axis_tuser), .s_tlast(s_axis_tlast),
    .can_load(can0),
    .m_tdata(m_axis_tdata_0), .m_tstrb(m_axis_tstrb_0), .m_tuser(m_axis_tuser_0),
    .m_tlast(m_axis_tlast_0), .m_tvalid(m_axis_tvalid_0), .m_tready(m_axis_tready_0)
  );
  axis_reg_slice #(.DW(C_AXIS_DATA_WIDTH), .TW(C_AXIS_TUSER_WIDTH)) u_slice_1 (
    .clk(axi_aclk), .rst_n(axi_aresetn), .load(load1),
    .s_tdata(s_axis_tdata), .s_tstrb(s_axis_tstrb), .s_tuser(s_axis_tuser), .s_tlast(s_axis_tlast),
    .can_load(can1),
    .m_tdata(m_axis_tdata_1), .m_tstrb(m_axis_tstrb_1), .m_tuser(m_axis_tuser_1),
    .m_tlast(m_axis_tlast_1), .m_tvalid(m_axis_tvalid_1), .m_tready(m_axis_tready_1)
  );
`ifdef PACKET_STEER_STATS_EN
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) begin
      pkt_cnt_0 <= '0;
      pkt_cnt_1 <= '0;
      drop_cnt  <= '0;
    end else begin
      pkt_cnt_0 <= pkt_cnt_0 + 32'(load0 && s_axis_tlast);
      pkt_cnt_1 <= pkt_cnt_1 + 32'(load1 && s_axis_tlast);
      drop_cnt  <= drop_cnt + 32'(xfer && s_axis_tlast && sel == SEL_DROP);
    end
`endif
endmodule

// File: tb/tb_packet_steer.sv
// tb_packet_steer: directed stimulus with a queue-based reference model checked every cycle
module tb_packet_steer;
  localparam int DW = 64;
  localparam int TW = 32;
  localparam int BW = DW + DW/8 + TW + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [DW/8-1:0] s_axis_tstrb = '0;
  logic [TW-1:0] s_axis_tuser = '0;
  logic s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
  logic [DW-1:0] m_axis_tdata_0, m_axis_tdata_1;
  logic [DW/8-1:0] m_axis_tstrb_0, m_axis_tstrb_1;
  logic [TW-1:0] m_axis_tuser_0, m_axis_tuser_1;
  logic m_axis_tvalid_0, m_axis_tvalid_1, m_axis_tlast_0, m_axis_tlast_1;
  logic m_axis_tready_0 = 1'b1, m_axis_tready_1 = 1'b1;
`ifdef PACKET_STEER_STATS_EN
  logic [31:0] pkt_cnt_0, pkt_cnt_1, drop_cnt;
`endif
  int checks = 0, errors = 0, cyc = 0;
  int n0 = 0, n1 = 0;
  logic [DW-1:0] lastd0 = '0, lastd1 = '0;
  logic lastl0 = 1'b0, lastl1 = 1'b0;
  logic [BW-1:0] q0[$], q1[$];
  logic first = 1'b1;
  logic [1:0] cur_sel = 2'b00;

  packet_steer #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(TW)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata_0(m_axis_tdata_0), .m_axis_tstrb_0(m_axis_tstrb_0), .m_axis_tuser_0(m_axis_tuser_0),
    .m_axis_tvalid_0(m_axis_tvalid_0), .m_axis_tlast_0(m_axis_tlast_0), .m_axis_tready_0(m_axis_tready_0),
    .m_axis_tdata_1(m_axis_tdata_1), .m_axis_tstrb_1(m_axis_tstrb_1), .m_axis_tuser_1(m_axis_tuser_1),
    .m_axis_tvalid_1(m_axis_tvalid_1), .m_axis_tlast_1(m_axis_tlast_1), .m_axis_tready_1(m_axis_tready_1)
`ifdef PACKET_STEER_STATS_EN
    , .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] route(input logic [7:0] d);
    return {(d & 8'hAA) != 8'h00, (d & 8'h55) != 8'h00};
  endfunction

  // reference model: one expected-beat queue per output, occupancy mirrors the slice
  always @(negedge clk) begin
    logic [1:0] s;
    logic exp_rdy;
    if (!rst_n) begin
      chk("rst_tvalid_0", 128'(m_axis_tvalid_0), 128'd0);
      chk("rst_tvalid_1", 128'(m_axis_tvalid_1), 128'd0);
      chk("rst_s_tready", 128'(s_axis_tready), 128'd0);
      q0.delete();
      q1.delete();
      first = 1'b1;
    end else begin
      chk("tvalid_0", 128'(m_axis_tvalid_0), 128'(q0.size() != 0));
      chk("tvalid_1", 128'(m_axis_tvalid_1), 128'(q1.size() != 0));
      if (m_axis_tvalid_0 && q0.size() != 0)
        chk("beat_0", 128'({m_axis_tdata_0, m_axis_tstrb_0, m_axis_tuser_0, m_axis_tlast_0}), 128'(q0[0]));
      if (m_axis_tvalid_1 && q1.size() != 0)
        chk("beat_1", 128'({m_axis_tdata_1, m_axis_tstrb_1, m_axis_tuser_1, m_axis_tlast_1}), 128'(q1[0]));
      s = first ? route(s_axis_tuser[31:24]) : cur_sel;
      exp_rdy = (!s[0] || q0.size() == 0 || m_axis_tready_0) && (!s[1] || q1.size() == 0 || m_axis_tready_1);
      chk("s_tready", 128'(s_axis_tready), 128'(exp_rdy));
      if (m_axis_tvalid_0 && m_axis_tready_0 && q0.size() != 0) begin
        void'(q0.pop_front());
        n0++;
        lastd0 = m_axis_tdata_0;
        lastl0 = m_axis_tlast_0;
      end
      if (m_axis_tvalid_1 && m_axis_tready_1 && q1.size() != 0) begin
        void'(q1.pop_front());
        n1++;
        lastd1 = m_axis_tdata_1;
        lastl1 = m_axis_tlast_1;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        if (first) cur_sel = s;
        if (s[0]) q0.push_back({s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast});
        if (s[1]) q1.push_back({s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast});
        first = s_axis_tlast;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // sends the first k beats of an n-beat packet; later beats carry a wrong dst byte
  task automatic send_pkt(input logic [7:0] dst, input int n, input int k, input int base);
    for (int i = 0; i < k; i++) begin
      int t = 0;
      logic acc = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 64'(base + i);
      s_axis_tstrb  = 8'(8'hFF >> (i % 8));
      s_axis_tuser  = {(i == 0) ? dst : ~dst, 8'h00, 16'(base + i)};
      s_axis_tlast  = (i == n - 1);
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = s_axis_tready;
        @(posedge clk);
        #1;
        t++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=stalled required=accepted beat %0d base %h", i, base);
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  initial begin
    int c0, c1, t0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tlast_0", 128'(m_axis_tlast_0), 128'd0);
    chk("reset_tdata_1", 128'(m_axis_tdata_1), 128'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    // 1: 4-beat packet to out0
    c0 = n0; c1 = n1;
    send_pkt(8'h01, 4, 4, 'h100);
    idle(3);
    chk("t1_n0", 128'(n0 - c0), 128'd4);
    chk("t1_n1", 128'(n1 - c1), 128'd0);
    chk("t1_last", 128'({lastd0, lastl0}), 128'({64'h103, 1'b1}));
    // 2: single-beat to out1, then next packet to out0
    c0 = n0; c1 = n1;
    send_pkt(8'h02, 1, 1, 'h200);
    send_pkt(8'h04, 1, 1, 'h210);
    idle(3);
    chk("t2_n1", 128'(n1 - c1), 128'd1);
    chk("t2_last1", 128'({lastd1, lastl1}), 128'({64'h200, 1'b1}));
    chk("t2_n0", 128'(n0 - c0), 128'd1);
    chk("t2_last0", 128'(lastd0), 128'h210);
    // 3: broadcast with out1 ready toggling
    c0 = n0; c1 = n1;
    fork
      send_pkt(8'h03, 3, 3, 'h300);
      repeat (8) begin
        @(posedge clk);
        #1 m_axis_tready_1 = ~m_axis_tready_1;
      end
    join
    m_axis_tready_1 = 1'b1;
    idle(4);
    chk("t3_n0", 128'(n0 - c0), 128'd3);
    chk("t3_n1", 128'(n1 - c1), 128'd3);
    chk("t3_last", 128'({lastd0, lastd1}), 128'({64'h302, 64'h302}));
`ifdef PACKET_STEER_STATS_EN
    chk("stat_pkt0", 128'(pkt_cnt_0), 128'd3);
    chk("stat_pkt1", 128'(pkt_cnt_1), 128'd2);
`endif
    // 4: drop packet consumed at one beat per cycle
    c0 = n0; c1 = n1; t0 = cyc;
    send_pkt(8'h00, 5, 5, 'h400);
    chk("t4_cycles", 128'(cyc - t0), 128'd5);
    idle(3);
    chk("t4_n0", 128'(n0 - c0), 128'd0);
    chk("t4_n1", 128'(n1 - c1), 128'd0);
`ifdef PACKET_STEER_STATS_EN
    chk("stat_drop", 128'(drop_cnt), 128'd1);
`endif
    // 5: out0 back-pressured, slice holds beat 1
    c0 = n0;
    m_axis_tready_0 = 1'b0;
    fork
      send_pkt(8'h01, 6, 6, 'h500);
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t5_hold_data", 128'(m_axis_tdata_0), 128'h500);
        chk("t5_hold_valid", 128'(m_axis_tvalid_0), 128'd1);
        chk("t5_stall", 128'(s_axis_tready), 128'd0);
        @(posedge clk);
        #1 m_axis_tready_0 = 1'b1;
      end
    join
    idle(3);
    chk("t5_n0", 128'(n0 - c0), 128'd6);
    chk("t5_last", 128'({lastd0, lastl0}), 128'({64'h505, 1'b1}));
    // 6: reset mid-packet, then a new packet to out1
    send_pkt(8'h01, 4, 2, 'h600);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_valid", 128'({m_axis_tvalid_0, m_axis_tvalid_1}), 128'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    c0 = n0; c1 = n1;
    send_pkt(8'h02, 2, 2, 'h700);
    idle(3);
    chk("t6_n1", 128'(n1 - c1), 128'd2);
    chk("t6_n0", 128'(n0 - c0), 128'd0);
    chk("t6_last1", 128'({lastd1, lastl1}), 128'({64'h701, 1'b1}));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
